uart_rx_ovs: RTL and testbench

UART_RX_OVS -- requirements
Module: uart_rx_ovs

---
 rtl/uart_rx_ovs.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver with a first-word-fall-through receive FIFO
// and sticky overrun/frame/parity error flags.
// Optional parity stage: define UART_RX_PARITY_EN to add the PAR state (sense set by PARITY_ODD).
module uart_rx_ovs #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OVS        = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              baud_tick,
    input  logic              rx,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              fifo_full,
    input  logic              err_clr,
    output logic              overrun_err,
    output logic              frame_err,
    output logic              parity_err
);

    localparam int unsigned CNT_W = $clog2(OVS);
    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVS / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic             PAR_SENSE = 1'(PARITY_ODD);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PAR     = 3'd3,
        STOP    = 3'd4,
        WAIT_HI = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd4,
        WAIT_HI = 3'd5
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                push_q, push_d;
    logic                rx_meta_q, rx_sync_q;
    logic                frame_set_c;
    logic                par_set_c;

    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                rd_valid_q, rd_valid_d;
    logic                fifo_full_q, fifo_full_d;
    logic                overrun_q, overrun_d;
    logic                frame_q, frame_d;
    logic                pop_c;
    logic                do_push_c;

    // Two-flop synchronizer; the line idles high so the flops reset to 1
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver state, tick/bit counters, shift register and push strobe
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            push_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            push_q  <= push_d;
        end
    end

    // Frame sequencing: every decision is taken on a baud_tick using the synchronized line
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        frame_set_c = 1'b0;
        par_set_c   = 1'b0;
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_sync_q) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rx_sync_q ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_sync_q, shift_q[DATA_W-1:1]};
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PAR;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PAR: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_d     = '0;
                        par_set_c = ((^shift_q) ^ rx_sync_q) != PAR_SENSE;
                        state_d   = STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_d = '0;
                        if (rx_sync_q) begin
                            push_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            frame_set_c = 1'b1;
                            state_d     = WAIT_HI;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_HI: begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FIFO pointers, level and sticky error flags; a full FIFO only accepts a push alongside a pop
    always_comb begin
        pop_c       = rd_en & rd_valid_q;
        do_push_c   = push_q & (~fifo_full_q | pop_c);
        wr_ptr_d    = wr_ptr_q + PTR_W'(do_push_c);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop_c);
        level_d     = level_q + LVL_W'(do_push_c) - LVL_W'(pop_c);
        rd_valid_d  = (level_d != '0);
        fifo_full_d = (level_d == LVL_FULL);
        overrun_d   = (push_q & fifo_full_q & ~pop_c) | (overrun_q & ~err_clr);
        frame_d     = frame_set_c | (frame_q & ~err_clr);
    end

    // FIFO control and status registers
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rd_valid_q  <= 1'b0;
            fifo_full_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rd_valid_q  <= rd_valid_d;
            fifo_full_q <= fifo_full_d;
            overrun_q   <= overrun_d;
            frame_q     <= frame_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads zero
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_c) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_q, parity_d;

    // Sticky parity flag; a set in the same cycle as err_clr wins
    always_comb begin
        parity_d = par_set_c | (parity_q & ~err_clr);
    end

    // Parity flag register
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity_err = parity_q;
`else
    // No parity bit on the line: the flag is constant and the parity sense has no effect
    assign parity_err = par_set_c & PAR_SENSE;
`endif

    assign rd_data     = mem_q[rd_ptr_q];
    assign rd_valid    = rd_valid_q;
    assign fifo_full   = fifo_full_q;
    assign overrun_err = overrun_q;
    assign frame_err   = frame_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs with a queue scoreboard of expected received words.
// Parity checks are compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx_ovs;

    localparam int DATA_W     = 8;
    localparam int OVS        = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int PARITY_ODD = 0;

    logic              clk = 1'b0;
    logic              Rst;
    logic              baud_tick;
    logic              rx;
    logic              rd_en;
    logic              err_clr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              fifo_full;
    logic              overrun_err;
    logic              frame_err;
    logic              parity_err;

    int checks = 0;
    int errors = 0;
    int tick_div = 0;
    logic [DATA_W-1:0] exp_q [$];

    uart_rx_ovs #(
        .DATA_W    (DATA_W),
        .OVS       (OVS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk        (clk),
        .Rst        (Rst),
        .baud_tick  (baud_tick),
        .rx         (rx),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fifo_full  (fifo_full),
        .err_clr    (err_clr),
        .overrun_err(overrun_err),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // baud_tick: one clk high out of every four, changed on the falling edge
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_div  = (tick_div == 3) ? 0 : tick_div + 1;
            baud_tick = (tick_div == 3);
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns just after the rising edge at which the DUT sees a baud_tick
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
    endtask

    // Drives one frame; the stop sample lands OVS/2+1 ticks into the stop bit
    task automatic send_frame(input logic [DATA_W-1:0] data, input logic par_bad,
                              input logic stop_val, input int stop_bits, input logic chk_lat);
        wait_ticks(1);
        @(negedge clk); rx = 1'b0;
        wait_ticks(OVS);
        for (int i = 0; i < DATA_W; i++) begin
            @(negedge clk); rx = data[i];
            wait_ticks(OVS);
        end
`ifdef UART_RX_PARITY_EN
        @(negedge clk); rx = (^data) ^ 1'(PARITY_ODD) ^ par_bad;
        wait_ticks(OVS);
`else
        if (par_bad) $display("note: parity request ignored in this build");
`endif
        @(negedge clk); rx = stop_val;
        wait_ticks(OVS / 2 + 1);
        if (chk_lat) begin
            @(negedge clk); chk1("push_lat_tick+0", rd_valid, 1'b0);
            @(negedge clk); chk1("push_lat_tick+1", rd_valid, 1'b1);
        end
        wait_ticks(stop_bits * OVS - OVS / 2 - 1);
        @(negedge clk); rx = 1'b1;
    endtask

    // Waits (bounded) for a word, compares it with the scoreboard head and pops it
    task automatic read_check(input string tag);
        int budget = 200;
        logic [DATA_W-1:0] exp;
        @(negedge clk);
        while (!rd_valid && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk1({tag, "_valid"}, rd_valid, 1'b1);
        chk1({tag, "_sb_has_entry"}, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            chkd({tag, "_data"}, rd_data, exp);
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_err_clr();
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_rd_valid"}, rd_valid, 1'b0);
        chk1({tag, "_fifo_full"}, fifo_full, 1'b0);
        chk1({tag, "_overrun"}, overrun_err, 1'b0);
        chk1({tag, "_frame"}, frame_err, 1'b0);
        chk1({tag, "_parity"}, parity_err, 1'b0);
        chkd({tag, "_rd_data"}, rd_data, '0);
    endtask

    initial begin
        logic [DATA_W-1:0] w;
        rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0; Rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        Rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single word with push latency
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b1, 1, 1'b1);
        read_check("w5a");
        @(negedge clk);
        chk1("w5a_popped", rd_valid, 1'b0);

        // False start: six ticks low then high
        wait_ticks(1);
        @(negedge clk); rx = 1'b0;
        wait_ticks(6);
        @(negedge clk); rx = 1'b1;
        wait_ticks(2 * OVS);
        chk1("false_start_no_push", rd_valid, 1'b0);
        chk1("false_start_no_frame", frame_err, 1'b0);
        chk1("false_start_no_overrun", overrun_err, 1'b0);

        // Break: stop bit held low three bit times, then a clean frame
        send_frame(8'h3C, 1'b0, 1'b0, 3, 1'b0);
        wait_ticks(2);
        chk1("break_frame_err", frame_err, 1'b1);
        chk1("break_no_push", rd_valid, 1'b0);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b1, 1, 1'b0);
        read_check("after_break");
        chk1("frame_err_sticky", frame_err, 1'b1);
        pulse_err_clr();
        chk1("frame_err_cleared", frame_err, 1'b0);

        // Overflow: five words, no reads
        for (int i = 0; i < 5; i++) begin
            w = DATA_W'(8'h11 * (i + 1));
            if (i < FIFO_DEPTH) exp_q.push_back(w);
            send_frame(w, 1'b0, 1'b1, 1, 1'b0);
        end
        wait_ticks(2);
        chk1("ovf_full", fifo_full, 1'b1);
        chk1("ovf_overrun", overrun_err, 1'b1);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            read_check("ovf_read");
            chk1("ovf_not_full", fifo_full, 1'b0);
        end
        chk1("ovf_drained", rd_valid, 1'b0);
        rd_en = 1'b1;
        repeat (3) @(negedge clk);
        rd_en = 1'b0;
        chk1("empty_pop_ignored", rd_valid, 1'b0);
        chk1("overrun_sticky", overrun_err, 1'b1);
        pulse_err_clr();
        chk1("overrun_cleared", overrun_err, 1'b0);

        // Pointers have wrapped; one more word through
        exp_q.push_back(8'hE7);
        send_frame(8'hE7, 1'b0, 1'b1, 1, 1'b0);
        read_check("wrap");

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: parity bit 0 is wrong for even sense, 1 is right
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1, 1'b0);
        read_check("par_bad");
        chk1("par_bad_flag", parity_err, 1'b1);
        pulse_err_clr();
        chk1("par_cleared", parity_err, 1'b0);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b0, 1'b1, 1, 1'b0);
        read_check("par_good");
        chk1("par_good_flag", parity_err, 1'b0);
`else
        chk1("parity_tied_low", parity_err, 1'b0);
`endif

        // Reset during data bit 3 with a word stored and frame_err set
        send_frame(8'h69, 1'b0, 1'b1, 1, 1'b0);
        send_frame(8'h00, 1'b0, 1'b0, 2, 1'b0);
        wait_ticks(2);
        chk1("pre_reset_valid", rd_valid, 1'b1);
        chk1("pre_reset_frame", frame_err, 1'b1);
        w = 8'h96;
        wait_ticks(1);
        @(negedge clk); rx = 1'b0;
        wait_ticks(OVS);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); rx = w[i];
            wait_ticks(OVS);
        end
        @(negedge clk); rx = w[3];
        wait_ticks(OVS / 2);
        @(negedge clk); Rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("mid_reset");
        rx = 1'b1;
        @(negedge clk); Rst = 1'b0;
        wait_ticks(2 * OVS);
        chk1("post_reset_no_push", rd_valid, 1'b0);
        chk1("post_reset_no_frame", frame_err, 1'b0);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b0, 1'b1, 1, 1'b0);
        read_check("post_reset");
        chk1("sb_drained", exp_q.size() == 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
